// File: rtl/tw_mult_gen_if.sv
// Sample/twiddle-ROM/result bundle for the twiddle multiplier.
// The master side is the surrounding datapath, which also hosts the ROM.
interface tw_mult_gen_if #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int AW = 9
);
  logic                 ce;
  logic                 sof;
  logic [AW-1:0]        stride;
  logic                 conj;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic [AW-1:0]        rom_ad;
  logic [2*TW-1:0]      rom_out;
  logic                 oe;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;
  logic                 ovf;

  modport master (
    output ce, sof, stride, conj, din_r, din_i, rom_out,
    input  rom_ad, oe, dout_r, dout_i, ovf
  );

  modport slave (
    input  ce, sof, stride, conj, din_r, din_i, rom_out,
    output rom_ad, oe, dout_r, dout_i, ovf
  );
endinterface

// File: rtl/tw_mult_gen.sv
// Twiddle complex multiplier: strided ROM addressing, 4-stage multiply,
// optional conjugate, round-half-up and saturate back to DW bits.
module tw_mult_gen #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  tw_mult_gen_if.slave  bus
);
  localparam int STAGES = 4;
  localparam int PW     = DW + TW;      // product width
  localparam int SW     = DW + TW + 2;  // sum + rounding headroom

  localparam logic signed [SW-1:0] RND  = {{(SW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // ---------------- address generator ----------------
  logic [AW-1:0] r_addr, r_stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_stride <= AW'(1);
    end else if (bus.ce) begin
      if (bus.sof) begin
        r_stride <= bus.stride;
        r_addr   <= bus.stride;
      end else begin
        r_addr <= r_addr + r_stride;
      end
    end
  end

  // r_addr already holds the next sample's address; only a frame start
  // overrides it, so the ROM latches the right word on the accept edge.
  assign bus.rom_ad = (bus.ce & bus.sof) ? '0 : r_addr;

  // ---------------- valid / conj shift pipelines ----------------
  logic [STAGES:1]   r_vld_pipe;
  logic [STAGES-2:1] r_cj_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_cj_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.ce};
      r_cj_pipe  <= {r_cj_pipe[STAGES-3:1], bus.conj};
    end
  end

  // ---------------- datapath ----------------
  logic signed [DW-1:0] r_ar, r_ai;
  logic signed [TW-1:0] w_wr, w_wi;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [PW:0]   w_rr, w_ii, w_ri, w_ir;
  logic signed [PW:0]   r_re, r_im;
  logic signed [SW-1:0] w_re_rnd, w_im_rnd, w_re_sh, w_im_sh;
  logic [DW:0]          w_sat_r, w_sat_i;

  assign w_wr = bus.rom_out[2*TW-1:TW];
  assign w_wi = bus.rom_out[TW-1:0];

  assign w_rr = {r_p_rr[PW-1], r_p_rr};
  assign w_ii = {r_p_ii[PW-1], r_p_ii};
  assign w_ri = {r_p_ri[PW-1], r_p_ri};
  assign w_ir = {r_p_ir[PW-1], r_p_ir};

  assign w_re_rnd = {r_re[PW], r_re} + RND;
  assign w_im_rnd = {r_im[PW], r_im} + RND;
  assign w_re_sh  = w_re_rnd >>> (TW-1);
  assign w_im_sh  = w_im_rnd >>> (TW-1);

  // {clamped flag, DW-bit result}
  function automatic logic [DW:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX)      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    else               return {1'b0, v[DW-1:0]};
  endfunction

  assign w_sat_r = sat(w_re_sh);
  assign w_sat_i = sat(w_im_sh);

  logic signed [DW-1:0] r_dout_r, r_dout_i;
  logic                 r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar     <= '0;
      r_ai     <= '0;
      r_p_rr   <= '0;
      r_p_ii   <= '0;
      r_p_ri   <= '0;
      r_p_ir   <= '0;
      r_re     <= '0;
      r_im     <= '0;
      r_dout_r <= '0;
      r_dout_i <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ar   <= bus.din_r;
      r_ai   <= bus.din_i;
      r_p_rr <= r_ar * w_wr;
      r_p_ii <= r_ai * w_wi;
      r_p_ri <= r_ar * w_wi;
      r_p_ir <= r_ai * w_wr;
      r_re   <= r_cj_pipe[2] ? (w_rr + w_ii) : (w_rr - w_ii);
      r_im   <= r_cj_pipe[2] ? (w_ir - w_ri) : (w_ri + w_ir);
      // outputs hold through input gaps
      if (r_vld_pipe[STAGES-1]) begin
        r_dout_r <= w_sat_r[DW-1:0];
        r_dout_i <= w_sat_i[DW-1:0];
        r_ovf    <= w_sat_r[DW] | w_sat_i[DW];
      end
    end
  end

  assign bus.oe     = r_vld_pipe[STAGES];
  assign bus.dout_r = r_dout_r;
  assign bus.dout_i = r_dout_i;
  assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_tw_mult_gen.sv
// Bench for tw_mult_gen: directed spec scenarios plus a randomized stream
// checked against a cycle-indexed arithmetic reference model.
module tb_tw_mult_gen;
  localparam int DW = 16, TW = 16, AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tw_mult_gen_if #(.DW(DW), .TW(TW), .AW(AW)) bus();
  tw_mult_gen #(.DW(DW), .TW(TW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [2*TW-1:0] rom [1<<AW];
  always @(posedge clk) bus.rom_out <= rom[bus.rom_ad];

  int total = 0, bad = 0;

  // ---------------- reference model ----------------
  int  m_addr = 0, m_stride = 1, cyc = 0, m_a, m_slot;
  bit  h_ce [16];
  int  h_r [16], h_i [16];
  bit  h_ov [16];
  bit  exp_oe = 0, exp_ov = 0;
  int  exp_r = 0, exp_i = 0;

  function automatic void ref_mul(input longint ar, ai, wr, wi, input bit cj,
                                  output int r, i, output bit ov);
    longint re, im, rr, ii;
    re = cj ? ar*wr + ai*wi : ar*wr - ai*wi;
    im = cj ? ai*wr - ar*wi : ar*wi + ai*wr;
    rr = (re + (longint'(1) << (TW-2))) >>> (TW-1);
    ii = (im + (longint'(1) << (TW-2))) >>> (TW-1);
    ov = 0;
    if (rr > 32767)  begin rr = 32767;  ov = 1; end
    if (rr < -32768) begin rr = -32768; ov = 1; end
    if (ii > 32767)  begin ii = 32767;  ov = 1; end
    if (ii < -32768) begin ii = -32768; ov = 1; end
    r = int'(rr);
    i = int'(ii);
  endfunction

  // A sample accepted on edge k is visible from edge k+3 onward (cyc == k+4).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = 0; m_stride = 1;
      foreach (h_ce[k]) h_ce[k] = 0;
      exp_oe = 0; exp_r = 0; exp_i = 0; exp_ov = 0;
    end else begin
      m_slot = cyc % 16;
      h_ce[m_slot] = bus.ce;
      if (bus.ce) begin
        m_a = bus.sof ? 0 : m_addr;
        ref_mul(longint'(bus.din_r), longint'(bus.din_i),
                longint'($signed(rom[m_a][2*TW-1:TW])), longint'($signed(rom[m_a][TW-1:0])),
                bus.conj, h_r[m_slot], h_i[m_slot], h_ov[m_slot]);
        if (bus.sof) m_stride = int'(bus.stride);
        m_addr = (m_a + m_stride) % (1 << AW);
      end
      cyc++;
      m_slot = (cyc + 12) % 16;
      exp_oe = h_ce[m_slot];
      if (exp_oe) begin
        exp_r = h_r[m_slot]; exp_i = h_i[m_slot]; exp_ov = h_ov[m_slot];
      end
    end
  end

  task automatic drive(input bit c, s, input int st, input bit cj, input int dr, di);
    @(negedge clk);
    bus.ce = c; bus.sof = s; bus.stride = st[AW-1:0]; bus.conj = cj;
    bus.din_r = dr[DW-1:0]; bus.din_i = di[DW-1:0];
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %0d want 0", bus.oe); end
    total++; if (bus.dout_r !== '0 || bus.dout_i !== '0) begin bad++; $display("FAIL reset_dout: got %0d/%0d want 0/0", bus.dout_r, bus.dout_i); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0d want 0", bus.ovf); end
    total++; if (bus.rom_ad !== '0) begin bad++; $display("FAIL reset_rom_ad: got %0d want 0", bus.rom_ad); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_identity();
    rom[0] = 32'h7FFF_0000;
    drive(1, 1, 1, 0, 1000, -2000);
    total++; if (bus.rom_ad !== '0) begin bad++; $display("FAIL ident_rom_ad: got %0d want 0", bus.rom_ad); end
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== 1'b0) begin bad++; $display("FAIL ident_early_oe: got %0d want 0", bus.oe); end
    end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.oe !== 1'b1) begin bad++; $display("FAIL ident_oe: got %0d want 1", bus.oe); end
    total++; if (bus.dout_r !== 16'sd1000 || bus.dout_i !== -16'sd2000 || bus.ovf !== 1'b0)
      begin bad++; $display("FAIL ident_dout: got %0d/%0d ovf %0d want 1000/-2000 ovf 0", bus.dout_r, bus.dout_i, bus.ovf); end
  endtask

  task automatic test_rotation();
    int wr[3] = '{-2000, 2000, -2000};
    int wi[3] = '{1000, -1000, 1000};
    for (int k = 0; k < 3; k++) rom[k] = 32'h0000_7FFF;
    drive(1, 1, 1, 0, 1000, 2000);
    drive(1, 0, 0, 1, 1000, 2000);
    drive(1, 0, 0, 0, 1000, 2000);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== 1'b1 || int'(bus.dout_r) !== wr[k] || int'(bus.dout_i) !== wi[k])
        begin bad++; $display("FAIL rot_%0d: got oe %0d %0d/%0d want 1 %0d/%0d", k, bus.oe, bus.dout_r, bus.dout_i, wr[k], wi[k]); end
    end
  endtask

  task automatic test_saturation();
    rom[0] = 32'h7FFF_7FFF;
    drive(1, 1, 1, 0, -32768, -32768);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.oe !== 1'b1 || bus.dout_r !== 16'sd0 || bus.dout_i !== -16'sd32768 || bus.ovf !== 1'b1)
      begin bad++; $display("FAIL sat: got oe %0d %0d/%0d ovf %0d want 1 0/-32768 ovf 1", bus.oe, bus.dout_r, bus.dout_i, bus.ovf); end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 130; n++) begin
      drive(1, n == 0, 4, 1'($urandom), int'($urandom), int'($urandom));
      total++; if (int'(bus.rom_ad) !== (4*n) % 512) begin bad++; $display("FAIL wrap_ad[%0d]: got %0d want %0d", n, bus.rom_ad, (4*n) % 512); end
      total++; if (bus.oe !== (n >= 4)) begin bad++; $display("FAIL wrap_oe[%0d]: got %0d want %0d", n, bus.oe, n >= 4); end
      total++; if (int'(bus.dout_r) !== exp_r || int'(bus.dout_i) !== exp_i || bus.ovf !== exp_ov)
        begin bad++; $display("FAIL wrap_dout[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n, bus.dout_r, bus.dout_i, bus.ovf, exp_r, exp_i, exp_ov); end
    end
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== (n < 4)) begin bad++; $display("FAIL wrap_tail_oe[%0d]: got %0d want %0d", n, bus.oe, n < 4); end
    end
  endtask

  task automatic test_gapped();
    bit pat[12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    int acc = 0;
    logic [DW-1:0] prev_r, prev_i;
    prev_r = bus.dout_r; prev_i = bus.dout_i;
    for (int n = 0; n < 12; n++) begin
      drive(pat[n], n == 0, 1, 1'($urandom), int'($urandom), int'($urandom));
      if (pat[n]) begin
        total++; if (int'(bus.rom_ad) !== acc) begin bad++; $display("FAIL gap_ad[%0d]: got %0d want %0d", n, bus.rom_ad, acc); end
        acc++;
      end
      total++; if (bus.oe !== (n >= 4 ? pat[n-4] : 1'b0)) begin bad++; $display("FAIL gap_oe[%0d]: got %0d", n, bus.oe); end
      if (!bus.oe) begin
        total++; if (bus.dout_r !== prev_r || bus.dout_i !== prev_i) begin bad++; $display("FAIL gap_hold[%0d]: got %0d/%0d want %0d/%0d", n, bus.dout_r, bus.dout_i, prev_r, prev_i); end
      end
      total++; if (int'(bus.dout_r) !== exp_r || int'(bus.dout_i) !== exp_i || bus.ovf !== exp_ov)
        begin bad++; $display("FAIL gap_dout[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n, bus.dout_r, bus.dout_i, bus.ovf, exp_r, exp_i, exp_ov); end
      prev_r = bus.dout_r; prev_i = bus.dout_i;
    end
  endtask

  task automatic test_reset_midframe();
    int ads[4] = '{0, 1, 0, 5};
    bit sofs[4] = '{0, 0, 1, 0};
    int strs[4] = '{7, 7, 5, 9};
    drive(1, 1, 2, 0, 12345, -321);
    drive(1, 0, 0, 1, -700, 4000);
    drive(1, 0, 0, 0, 30000, 30000);
    @(negedge clk); bus.ce = 1'b0; rst_n = 1'b0; #1;
    total++; if (bus.oe !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0 || bus.ovf !== 1'b0)
      begin bad++; $display("FAIL midrst_out: got oe %0d %0d/%0d ovf %0d want all 0", bus.oe, bus.dout_r, bus.dout_i, bus.ovf); end
    total++; if (bus.rom_ad !== '0) begin bad++; $display("FAIL midrst_ad: got %0d want 0", bus.rom_ad); end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== 1'b0) begin bad++; $display("FAIL midrst_oe[%0d]: got %0d want 0", n, bus.oe); end
    end
    // stride stays at its reset value of 1 until a frame start samples a new one
    for (int n = 0; n < 4; n++) begin
      drive(1, sofs[n], strs[n], 0, int'($urandom), int'($urandom));
      total++; if (int'(bus.rom_ad) !== ads[n]) begin bad++; $display("FAIL midrst_seq[%0d]: got %0d want %0d", n, bus.rom_ad, ads[n]); end
    end
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== (n < 4) || int'(bus.dout_r) !== exp_r || int'(bus.dout_i) !== exp_i)
        begin bad++; $display("FAIL midrst_dout[%0d]: got oe %0d %0d/%0d want %0d %0d/%0d", n, bus.oe, bus.dout_r, bus.dout_i, n < 4, exp_r, exp_i); end
    end
  endtask

  task automatic test_random();
    bit c, s;
    int dr, di, xad;
    for (int n = 0; n < 400; n++) begin
      c  = (n == 0) || ($urandom_range(0, 3) != 0);
      s  = (n == 0) || ($urandom_range(0, 31) == 0);
      dr = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      di = ($urandom_range(0, 7) == 0) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
      drive(c, s, int'($urandom_range(0, 511)), 1'($urandom), dr, di);
      xad = (c && s) ? 0 : m_addr;
      total++; if (int'(bus.rom_ad) !== xad) begin bad++; $display("FAIL rnd_ad[%0d]: got %0d want %0d", n, bus.rom_ad, xad); end
      total++; if (bus.oe !== exp_oe || int'(bus.dout_r) !== exp_r || int'(bus.dout_i) !== exp_i || bus.ovf !== exp_ov)
        begin bad++; $display("FAIL rnd_out[%0d]: got %0d %0d/%0d/%0d want %0d %0d/%0d/%0d", n, bus.oe, bus.dout_r, bus.dout_i, bus.ovf, exp_oe, exp_r, exp_i, exp_ov); end
    end
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++; if (bus.oe !== exp_oe || int'(bus.dout_r) !== exp_r || int'(bus.dout_i) !== exp_i || bus.ovf !== exp_ov)
        begin bad++; $display("FAIL rnd_tail[%0d]: got %0d %0d/%0d/%0d want %0d %0d/%0d/%0d", n, bus.oe, bus.dout_r, bus.dout_i, bus.ovf, exp_oe, exp_r, exp_i, exp_ov); end
    end
  endtask

  initial begin
    bus.ce = 0; bus.sof = 0; bus.stride = '0; bus.conj = 0; bus.din_r = '0; bus.din_i = '0;
    for (int k = 0; k < (1 << AW); k++) rom[k] = $urandom;
    test_reset();
    test_identity();
    test_rotation();
    test_saturation();
    test_wrap();
    test_gapped();
    test_reset_midframe();
    for (int k = 0; k < (1 << AW); k++) rom[k] = $urandom;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tw_mult_gen.md
# tw_mult_gen

Parametrised twiddle-factor complex multiplier for the FFT butterfly datapath: it generates twiddle ROM addresses with a programmable stride, multiplies each input sample by the returned twiddle (optionally conjugated for inverse FFT), and rounds and saturates the result back to the data width. It sits between a butterfly stage output and the next stage input. It replaces the fixed 16-bit, vendor-IP, fixed-stride multiplier with a native fully-pipelined datapath that accepts gapped input streams.

## Interface
- DW, 16: data width of din/dout, two's complement, per real/imag part
- TW, 16: twiddle width per part, Q1.(TW-1) signed
- AW, 9: ROM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- ce  in  1  input sample valid; one sample accepted per cycle with ce=1
- sof  in  1  start of frame, qualified by ce; restarts address sequence
- stride  in  AW  address increment per sample; sampled when ce&sof
- conj  in  1  per-sample: 1 = multiply by conjugate twiddle
- din_r, din_i  in  DW  input sample, signed
- rom_ad  out  AW  twiddle ROM address (registered)
- rom_out  in  2*TW  ROM data, 1-cycle synchronous read; [2TW-1:TW]=wr, [TW-1:0]=wi
- oe  out  1  output valid
- dout_r, dout_i  out  DW  product, signed
- ovf  out  1  saturation occurred on this output sample (either part); valid with oe

## Operation
- Address generator: register addr (AW bits) and stride_q. When ce&sof: sample stride_q<=stride, this sample uses address 0, next address = stride. When ce&!sof: this sample uses addr, next = addr+stride_q mod 2^AW (wrap silently). ce=0: addr holds (gaps allowed mid-frame).
- rom_ad is driven so that the ROM's registered output for sample accepted in cycle t appears on rom_out in cycle t+1.
- Stage 1 (cycle t edge): capture din_r, din_i, conj, valid.
- Stage 2 (t+1 edge): four signed products ar*wr, ai*wi, ar*wi, ai*wr, each DW+TW bits, registered.
- Stage 3 (t+2 edge): conj=0: re=ar*wr-ai*wi, im=ar*wi+ai*wr. conj=1: re=ar*wr+ai*wi, im=ai*wr-ar*wi. Width DW+TW+1, registered.
- Stage 4 (t+3 edge): add 2^(TW-2), arithmetic shift right TW-1 (round half up), clamp to [-2^(DW-1), 2^(DW-1)-1]; ovf=1 if either part clamped.
- Valid, conj travel in a shift pipeline alongside data; no backpressure, no stall.
- dout_r/dout_i/ovf update only when pipeline stage-4 valid is 1; hold otherwise.

## Timing
- Latency: sample with ce=1 in cycle t appears with oe=1 in cycle t+4; throughput 1 sample/cycle.
- oe is exactly the ce pattern delayed 4 cycles (gaps preserved).
- Reset values: rom_ad=0, oe=0, dout_r=0, dout_i=0, ovf=0; addr=0, stride_q=1, all pipeline valid bits 0.
- Reset asserted mid-stream: all in-flight samples discarded; no oe after release until 4 cycles after the next ce.
- ce&sof while a previous frame is in flight: in-flight samples complete normally with their original twiddles; new frame starts at address 0.
- Stride change without sof is ignored.
- Address wrap: addr+stride_q overflowing 2^AW wraps modulo 2^AW, no flag.

## Test plan
- Identity: DW=TW=16, ROM word wr=0x7FFF wi=0, din=1000 + j(-2000), conj=0 -> dout=1000 + j(-2000) at t+4, ovf=0.
- Rotation by j: wr=0, wi=0x7FFF, din=1000+j2000; conj=0 -> -2000+j1000; conj=1 -> 2000+j(-1000); conj toggled on back-to-back samples, each output uses its own conj.
- Saturation: din=-32768+j(-32768), wr=wi=0x7FFF -> dout_r=0, dout_i=-32768, ovf=1.
- Address/wrap: AW=9, sof with stride=4, 130 consecutive samples -> rom_ad 0,4,...,508,0,4; oe high for 130 cycles starting 4 cycles after first ce.
- Gapped stream: ce pattern 1,0,0,1,1,0,1 after sof stride=1 -> rom_ad sequence 0,1,2,3 on accepted samples; oe pattern identical delayed 4 cycles; dout holds during gaps.
- Reset mid-frame: assert rst for 1 cycle with 3 samples in flight -> all outputs 0 immediately, no oe for those samples; next sof frame starts at rom_ad 0.
